// File: rtl/mips_ctrl_fsm_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_fsm_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - opcode values decoded from instruction[31:26]
//   - ALU operation, ALUSrcB and PCSrc select codes driven to the datapath
//   - FSM state encoding (also visible on state_dbg)
//   - packed control word produced by the state decoder
// -----------------------------------------------------------------------------
package mips_ctrl_fsm_pkg;

  // Opcode field values
  localparam logic [5:0] OPC_R    = 6'b000000;
  localparam logic [5:0] OPC_LW   = 6'b100011;
  localparam logic [5:0] OPC_SW   = 6'b101011;
  localparam logic [5:0] OPC_BEQ  = 6'b000100;
  localparam logic [5:0] OPC_ADDI = 6'b001000;
  localparam logic [5:0] OPC_J    = 6'b000010;

  // ula_operation codes (consumed by ula_control)
  localparam logic [1:0] ULA_ADD   = 2'b00;
  localparam logic [1:0] ULA_SUB   = 2'b01;
  localparam logic [1:0] ULA_FUNCT = 2'b10;

  // ALUSrcB selects
  localparam logic [1:0] SRCB_RD2     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // PCSrc selects
  localparam logic [1:0] PCSRC_ULA    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // One state per instruction phase; encodings 12..15 are unused.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // Full set of datapath controls for one cycle
  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ula_op;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // True for the six opcodes this control unit implements
  function automatic logic is_known_opcode(input logic [5:0] opc);
    return (opc == OPC_R)   || (opc == OPC_LW)   || (opc == OPC_SW) ||
           (opc == OPC_BEQ) || (opc == OPC_ADDI) || (opc == OPC_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// -----------------------------------------------------------------------------
// mips_ctrl_decode
// Combinational state -> control word decoder. Every field defaults to 0 and
// each state raises only the controls it needs. IRWrite/PCWrite/instr_done are
// the only fields that also depend on mem_ready or ula_zero.
// Ports:
//   state_i      current FSM state
//   opc_known_i  opcode is one of the implemented instructions
//   mem_ready_i  effective memory handshake (already forced high if unused)
//   ula_zero_i   ULA zero flag for beq
//   ctrl_o       control word for this cycle
// -----------------------------------------------------------------------------
module mips_ctrl_decode
  import mips_ctrl_fsm_pkg::*;
(
  input  state_e state_i,
  input  logic   opc_known_i,
  input  logic   mem_ready_i,
  input  logic   ula_zero_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed with the IR
        // once the memory returns the instruction.
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ula_op    = ULA_ADD;
        ctrl_o.pc_src    = PCSRC_ULA;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        // Branch target precompute: PC + (signext << 2) lands in ALUOut.
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.ula_op     = ULA_ADD;
        ctrl_o.illegal_op = ~opc_known_i;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.ula_op    = ULA_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_RD2;
        ctrl_o.ula_op    = ULA_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.ula_op    = ULA_ADD;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BRANCH: begin
        // Compare rs-rt; PC is loaded from ALUOut only when they are equal.
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_RD2;
        ctrl_o.ula_op     = ULA_SUB;
        ctrl_o.pc_src     = PCSRC_ALUOUT;
        ctrl_o.pc_write   = ula_zero_i;
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_src     = PCSRC_JUMP;
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// mips_ctrl_fsm
// Multicycle MIPS control unit. A Moore FSM walks each instruction through its
// phases (FETCH, DECODE, then an opcode-specific path) and drives every control
// input of the datapath. Memory phases wait on mem_ready.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   opcode              instruction[31:26] from the instruction register
//   mem_ready           memory finished the current read/write this cycle
//   ula_zero            ULA zero flag (beq compare)
//   IorD .. PCWrite     datapath mux selects and write enables
//   instr_done          pulse on the last cycle of each instruction
//   illegal_op          pulse in DECODE for an unimplemented opcode
//   state_dbg           current state encoding
// While reset is high every output is held at 0, so an aborted instruction
// can never leave a stray register or memory write behind.
// -----------------------------------------------------------------------------
module mips_ctrl_fsm
  import mips_ctrl_fsm_pkg::*;
#(
  parameter int OPC_W         = 6,
  parameter int STATE_W       = 4,
  parameter int USE_MEM_READY = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               mem_ready,
  input  logic               ula_zero,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ula_operation,
  output logic [1:0]         PCSrc,
  output logic               PCWrite,
  output logic               instr_done,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_dbg
);

  state_e     state_q;
  state_e     state_d;
  logic [5:0] opc;
  logic       mem_rdy;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;

  assign opc     = 6'(opcode);
  assign mem_rdy = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opc)
          OPC_LW, OPC_SW: state_d = S_MEMADR;
          OPC_R:          state_d = S_EXEC;
          OPC_ADDI:       state_d = S_ADDIEX;
          OPC_BEQ:        state_d = S_BRANCH;
          OPC_J:          state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // The IR holds the opcode, so it still selects load vs store here;
        // anything else means the IR was disturbed and we restart.
        if (opc == OPC_LW) begin
          state_d = S_MEMRD;
        end else if (opc == OPC_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state_i     (state_q),
    .opc_known_i (is_known_opcode(opc)),
    .mem_ready_i (mem_rdy),
    .ula_zero_i  (ula_zero),
    .ctrl_o      (ctrl)
  );

  // Combinational reset gate: reset kills the write enables in the same
  // cycle it rises, not at the next clock edge.
  assign ctrl_out = reset ? '0 : ctrl;

  assign IorD          = ctrl_out.iord;
  assign MemRead       = ctrl_out.mem_read;
  assign MemWrite      = ctrl_out.mem_write;
  assign IRWrite       = ctrl_out.ir_write;
  assign RegDst        = ctrl_out.reg_dst;
  assign MemtoReg      = ctrl_out.mem_to_reg;
  assign RegWrite      = ctrl_out.reg_write;
  assign ALUSrcA       = ctrl_out.alu_src_a;
  assign ALUSrcB       = ctrl_out.alu_src_b;
  assign ula_operation = ctrl_out.ula_op;
  assign PCSrc         = ctrl_out.pc_src;
  assign PCWrite       = ctrl_out.pc_write;
  assign instr_done    = ctrl_out.instr_done;
  assign illegal_op    = ctrl_out.illegal_op;
  assign state_dbg     = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
module tb_mips_ctrl_fsm;
  import mips_ctrl_fsm_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       ula_zero;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ula_operation, PCSrc;
  logic       PCWrite, instr_done, illegal_op;
  logic [3:0] state_dbg;
  logic [16:0] obs_vec;

  mips_ctrl_fsm dut (
    .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .ula_zero(ula_zero), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ula_operation(ula_operation),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .instr_done(instr_done),
    .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  assign obs_vec = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    ALUSrcB, ula_operation, PCSrc, PCWrite, instr_done, illegal_op};

  // Bit positions inside obs_vec
  localparam int B_MWR = 14, B_IRW = 13, B_M2R = 11, B_RW = 10, B_PCW = 2, B_DONE = 1, B_ILL = 0;

  // Instruction phases (bench-side names)
  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_MEMADR = 2, PH_MEMRD = 3, PH_MEMWB = 4,
                 PH_MEMWR = 5, PH_EXEC = 6, PH_ALUWB = 7, PH_ADDIEX = 8, PH_ADDIWB = 9,
                 PH_BRANCH = 10, PH_JUMP = 11;

  int vectors = 0;
  int miscompares = 0;

  int          plan_ph[$];
  bit          plan_mr[$];
  logic [16:0] got_vec[$];
  logic [3:0]  got_st[$];
  logic [5:0]  cur_opc;
  bit          cur_z;

  function automatic bit known(input logic [5:0] o);
    return o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
           o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
  endfunction

  // Expected control outputs for a phase, written straight from the control table
  function automatic logic [16:0] exp_vec(input int ph, input bit mr, input bit z, input logic [5:0] o);
    bit iord = 0, mrd = 0, mwr = 0, irw = 0, rdst = 0, m2r = 0, rw = 0, srca = 0;
    bit pcw = 0, done = 0, ill = 0;
    logic [1:0] srcb = 2'b00, op = 2'b00, pcs = 2'b00;
    case (ph)
      PH_FETCH:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
      PH_DECODE: begin srcb = 2'b11; ill = !known(o); end
      PH_MEMADR: begin srca = 1; srcb = 2'b10; end
      PH_MEMRD:  begin mrd = 1; iord = 1; end
      PH_MEMWB:  begin m2r = 1; rw = 1; done = 1; end
      PH_MEMWR:  begin mwr = 1; iord = 1; done = mr; end
      PH_EXEC:   begin srca = 1; op = 2'b10; end
      PH_ALUWB:  begin rdst = 1; rw = 1; done = 1; end
      PH_ADDIEX: begin srca = 1; srcb = 2'b10; end
      PH_ADDIWB: begin rw = 1; done = 1; end
      PH_BRANCH: begin srca = 1; op = 2'b01; pcs = 2'b01; pcw = z; done = 1; end
      PH_JUMP:   begin pcs = 2'b10; pcw = 1; done = 1; end
      default: ;
    endcase
    return {iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, op, pcs, pcw, done, ill};
  endfunction

  function automatic logic [3:0] ph_state(input int ph);
    state_e s;
    case (ph)
      PH_FETCH: s = S_FETCH;   PH_DECODE: s = S_DECODE; PH_MEMADR: s = S_MEMADR;
      PH_MEMRD: s = S_MEMRD;   PH_MEMWB: s = S_MEMWB;   PH_MEMWR: s = S_MEMWR;
      PH_EXEC: s = S_EXEC;     PH_ALUWB: s = S_ALUWB;   PH_ADDIEX: s = S_ADDIEX;
      PH_ADDIWB: s = S_ADDIWB; PH_BRANCH: s = S_BRANCH; default: s = S_JUMP;
    endcase
    return s;
  endfunction

  function automatic bit rbit();
    return bit'($urandom_range(1, 0));
  endfunction

  // Phase sequence an instruction must follow, with the mem_ready to drive each cycle
  task automatic build_plan(input logic [5:0] o, input int fs, input int ms, input bit z);
    plan_ph.delete(); plan_mr.delete();
    cur_opc = o; cur_z = z;
    repeat (fs) begin plan_ph.push_back(PH_FETCH); plan_mr.push_back(1'b0); end
    plan_ph.push_back(PH_FETCH);  plan_mr.push_back(1'b1);
    plan_ph.push_back(PH_DECODE); plan_mr.push_back(rbit());
    case (o)
      6'b100011: begin
        plan_ph.push_back(PH_MEMADR); plan_mr.push_back(rbit());
        repeat (ms) begin plan_ph.push_back(PH_MEMRD); plan_mr.push_back(1'b0); end
        plan_ph.push_back(PH_MEMRD); plan_mr.push_back(1'b1);
        plan_ph.push_back(PH_MEMWB); plan_mr.push_back(rbit());
      end
      6'b101011: begin
        plan_ph.push_back(PH_MEMADR); plan_mr.push_back(rbit());
        repeat (ms) begin plan_ph.push_back(PH_MEMWR); plan_mr.push_back(1'b0); end
        plan_ph.push_back(PH_MEMWR); plan_mr.push_back(1'b1);
      end
      6'b000000: begin
        plan_ph.push_back(PH_EXEC);  plan_mr.push_back(rbit());
        plan_ph.push_back(PH_ALUWB); plan_mr.push_back(rbit());
      end
      6'b001000: begin
        plan_ph.push_back(PH_ADDIEX); plan_mr.push_back(rbit());
        plan_ph.push_back(PH_ADDIWB); plan_mr.push_back(rbit());
      end
      6'b000100: begin plan_ph.push_back(PH_BRANCH); plan_mr.push_back(rbit()); end
      6'b000010: begin plan_ph.push_back(PH_JUMP);   plan_mr.push_back(rbit()); end
      default: ;
    endcase
  endtask

  // Entered #1 after a rising edge; drives n cycles and records what the DUT shows
  task automatic drive_plan(input int n);
    got_vec.delete(); got_st.delete();
    for (int i = 0; i < n; i++) begin
      opcode = cur_opc; ula_zero = cur_z; mem_ready = plan_mr[i];
      @(negedge clock);
      got_vec.push_back(obs_vec);
      got_st.push_back(state_dbg);
      @(posedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = 6'b101011; mem_ready = 1'b1; ula_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (obs_vec !== 17'd0 || state_dbg !== 4'd0) begin
        miscompares++;
        $display("FAIL reset_hold cyc %0d: got ctrl=%b st=%0d, want ctrl=0 st=0", i, obs_vec, state_dbg);
      end
    end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_rtype();
    int dones = 0;
    build_plan(6'b000000, 0, 0, rbit());
    drive_plan(plan_ph.size());
    for (int i = 0; i < plan_ph.size(); i++) begin
      vectors++;
      if (got_vec[i] !== exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc) || got_st[i] !== ph_state(plan_ph[i])) begin
        miscompares++;
        $display("FAIL rtype cyc %0d: got ctrl=%b st=%0d, want ctrl=%b st=%0d", i, got_vec[i], got_st[i],
                 exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc), ph_state(plan_ph[i]));
      end
      dones += int'(got_vec[i][B_DONE]);
    end
    vectors++;
    if (dones != 1 || plan_ph.size() != 4) begin
      miscompares++;
      $display("FAIL rtype_done: got %0d pulses in %0d cycles, want 1 in 4", dones, plan_ph.size());
    end
  endtask

  task automatic test_lw_stalls();
    int irw = 0, done_at = -1;
    build_plan(6'b100011, 2, 3, rbit());
    drive_plan(plan_ph.size());
    for (int i = 0; i < plan_ph.size(); i++) begin
      vectors++;
      if (got_vec[i] !== exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc) || got_st[i] !== ph_state(plan_ph[i])) begin
        miscompares++;
        $display("FAIL lw cyc %0d: got ctrl=%b st=%0d, want ctrl=%b st=%0d", i, got_vec[i], got_st[i],
                 exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc), ph_state(plan_ph[i]));
      end
      irw += int'(got_vec[i][B_IRW]);
      if (got_vec[i][B_DONE] && done_at < 0) done_at = i;
    end
    vectors++;
    if (irw != 1 || done_at + 1 != 10 || got_vec[9][B_M2R] !== 1'b1) begin
      miscompares++;
      $display("FAIL lw_latency: got irwrite=%0d cycles=%0d memtoreg=%b, want 1 10 1", irw, done_at + 1, got_vec[9][B_M2R]);
    end
  endtask

  task automatic test_beq();
    for (int zz = 1; zz >= 0; zz--) begin
      build_plan(6'b000100, 0, 0, bit'(zz));
      drive_plan(plan_ph.size());
      for (int i = 0; i < plan_ph.size(); i++) begin
        vectors++;
        if (got_vec[i] !== exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc) || got_st[i] !== ph_state(plan_ph[i])) begin
          miscompares++;
          $display("FAIL beq z=%0d cyc %0d: got ctrl=%b st=%0d, want ctrl=%b st=%0d", zz, i, got_vec[i], got_st[i],
                   exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc), ph_state(plan_ph[i]));
        end
      end
      vectors++;
      if (got_vec[2][B_PCW] !== bit'(zz) || got_vec[2][4:3] !== 2'b01 || state_dbg !== 4'(S_FETCH)) begin
        miscompares++;
        $display("FAIL beq_pc z=%0d: got pcwrite=%b pcsrc=%b next=%0d, want %0d 01 FETCH", zz,
                 got_vec[2][B_PCW], got_vec[2][4:3], state_dbg, zz);
      end
    end
  endtask

  task automatic test_illegal();
    int ill = 0, wr = 0;
    build_plan(6'b111111, 1, 0, rbit());
    drive_plan(plan_ph.size());
    for (int i = 0; i < plan_ph.size(); i++) begin
      vectors++;
      if (got_vec[i] !== exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc) || got_st[i] !== ph_state(plan_ph[i])) begin
        miscompares++;
        $display("FAIL illegal cyc %0d: got ctrl=%b st=%0d, want ctrl=%b st=%0d", i, got_vec[i], got_st[i],
                 exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc), ph_state(plan_ph[i]));
      end
      ill += int'(got_vec[i][B_ILL]);
      wr  += int'(got_vec[i][B_RW]) + int'(got_vec[i][B_MWR]);
    end
    vectors++;
    if (ill != 1 || wr != 0 || state_dbg !== 4'(S_FETCH)) begin
      miscompares++;
      $display("FAIL illegal_summary: got pulses=%0d writes=%0d next=%0d, want 1 0 FETCH", ill, wr, state_dbg);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0, mw_bad = 0;
    logic [5:0] seq [2];
    seq[0] = 6'b101011; seq[1] = 6'b000010;
    for (int k = 0; k < 2; k++) begin
      build_plan(seq[k], 0, 1, rbit());
      drive_plan(plan_ph.size());
      for (int i = 0; i < plan_ph.size(); i++) begin
        vectors++;
        if (got_vec[i] !== exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc) || got_st[i] !== ph_state(plan_ph[i])) begin
          miscompares++;
          $display("FAIL b2b instr %0d cyc %0d: got ctrl=%b st=%0d, want ctrl=%b st=%0d", k, i, got_vec[i], got_st[i],
                   exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc), ph_state(plan_ph[i]));
        end
        dones += int'(got_vec[i][B_DONE]);
        if (got_vec[i][B_MWR] !== (plan_ph[i] == PH_MEMWR)) mw_bad++;
      end
    end
    vectors++;
    if (dones != 2 || mw_bad != 0) begin
      miscompares++;
      $display("FAIL b2b_summary: got done=%0d stray_memwrite=%0d, want 2 0", dones, mw_bad);
    end
  endtask

  task automatic test_reset_mid_memwr();
    build_plan(6'b101011, 0, 4, 1'b0);
    drive_plan(4);  // FETCH, DECODE, MEMADR, first stalled MEMWR
    opcode = 6'b101011; mem_ready = 1'b0;
    #2;
    vectors++;
    if (MemWrite !== 1'b1 || state_dbg !== 4'(S_MEMWR)) begin
      miscompares++;
      $display("FAIL pre_abort: got memwrite=%b st=%0d, want 1 MEMWR", MemWrite, state_dbg);
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    vectors++;
    if (obs_vec !== 17'd0 || state_dbg !== 4'd0) begin
      miscompares++;
      $display("FAIL abort_gate: got ctrl=%b st=%0d, want all 0", obs_vec, state_dbg);
    end
    @(posedge clock); #1;
    reset = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    vectors++;
    if (state_dbg !== 4'(S_FETCH) || obs_vec !== exp_vec(PH_FETCH, 1'b0, 1'b0, opcode)) begin
      miscompares++;
      $display("FAIL post_abort: got ctrl=%b st=%0d, want FETCH ctrl=%b", obs_vec, state_dbg,
               exp_vec(PH_FETCH, 1'b0, 1'b0, opcode));
    end
    @(posedge clock); #1;
  endtask

  task automatic test_random();
    logic [5:0] ops [7];
    logic [5:0] o;
    int bad;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
    ops[4] = 6'b001000; ops[5] = 6'b000010; ops[6] = 6'b000000;
    for (int n = 0; n < 40; n++) begin
      o = ops[$urandom_range(6, 0)];
      if (n % 7 == 6) o = 6'($urandom_range(63, 0));
      build_plan(o, $urandom_range(2, 0), $urandom_range(2, 0), rbit());
      drive_plan(plan_ph.size());
      bad = 0;
      for (int i = 0; i < plan_ph.size(); i++) begin
        if (got_vec[i] !== exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc) || got_st[i] !== ph_state(plan_ph[i])) begin
          if (bad == 0)
            $display("FAIL random %0d opc=%b cyc %0d: got ctrl=%b st=%0d, want ctrl=%b st=%0d", n, o, i, got_vec[i],
                     got_st[i], exp_vec(plan_ph[i], plan_mr[i], cur_z, cur_opc), ph_state(plan_ph[i]));
          bad++;
        end
      end
      vectors++;
      if (bad != 0) miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_stalls();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_mid_memwr();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
